cfg_sclk_sequencer: RTL and testbench
=====================================

Name: cfg_sclk_sequencer

Overview:
- Generates bursts of a programmable-ratio serial configuration clock for the pixel-config shift chain.
- Entirely in the clkin domain, with registered glitch-free outputs.
- The host programs the divide ratio, then requests a burst of nbits clock periods.
- The block reports busy/done and the current bit index, and gives the shift-data logic one-cycle rise/fall strobes.

Parameters:
- DIV_W, 8, width of divide-ratio register.
- CNT_W, 16, width of burst length and bit index.
- DEFAULT_DIV, 5, divide ratio loaded at reset.

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- div_wr  in  1  one-cycle strobe; write divide ratio.
- div_val  in  DIV_W  requested divide ratio D.
- start  in  1  one-cycle strobe; request burst.
- nbits  in  CNT_W  burst length in sclk periods; sampled with start.
- abort  in  1  terminate burst in progress.
- busy  out  1  burst active.
- done  out  1  one-cycle pulse at burst end (normal, abort, or nbits=0).
- aborted  out  1  last burst ended by abort; held until next accepted start.
- sclk_out  out  1  divided serial clock, registered.
- sclk_rise  out  1  high in first cycle of each sclk_out high phase.
- sclk_fall  out  1  high in first cycle of each sclk_out low phase.
- bit_idx  out  CNT_W  index of current sclk period, 0..nbits-1; 0 when idle.
- div_cur  out  DIV_W  divide ratio currently in effect.

Behaviour:
- Reset (synchronous, active-high) returns the block to IDLE, so reset mid-burst stops at once with no done pulse. Values after reset:
  - div_cur = DEFAULT_DIV.
  - busy, done, aborted, sclk_out, sclk_rise, sclk_fall, bit_idx = 0.
  - pending-divisor flag cleared.
- Ratio clamp: div_val 0 or 1 is stored as 2. The legal range is 2..2^DIV_W-1.
- Phase lengths:
  - H = D - (D>>1) (high cycles).
  - L = D>>1 (low cycles).
  - Examples: D=5 gives H=3, L=2; D=4 gives H=2, L=2.
- States are IDLE and RUN.
- IDLE:
  - start with nbits != 0 moves to RUN on the next edge.
  - From the cycle after start: busy=1, sclk_out=1, sclk_rise=1, bit_idx=0, aborted=0.
  - nbits is latched at acceptance.
- RUN:
  - Phase counter runs 0..D-1.
  - sclk_out is high for counts 0..H-1 and low for counts H..D-1.
  - sclk_fall is high in the cycle at count H.
  - bit_idx increments in the cycle where sclk_rise is asserted for the next period.
- Normal end:
  - After the last low cycle of period nbits-1, the next cycle has state IDLE, busy=0, done=1 for one cycle, sclk_out=0, bit_idx=0.
  - Total busy cycles = nbits*D.
- Back-to-back: start in the same cycle as done is accepted, and the new burst begins on the following cycle.
- start with nbits=0 in IDLE: done=1 on the next cycle, with no busy and no sclk activity.
- start while busy is ignored and not queued.
- abort:
  - abort in RUN gives, on the next cycle: sclk_out=0 (no sclk_fall), busy=0, done=1, aborted=1, state IDLE.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- div_wr in IDLE: div_cur updates on the next edge. With div_wr and start in the same cycle, the new ratio applies to that burst.
- div_wr during RUN:
  - Value is held as pending; the last write wins.
  - The running burst keeps its ratio.
  - Pending is applied in the cycle done asserts, and cleared.
- All outputs come straight from flops, with no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start with nbits=3, D=5:
  - sclk_out = 11100 repeated 3 times.
  - busy high for 15 cycles; done in cycle 16 after start.
  - bit_idx steps 0,1,2; rise/fall strobes at cycle offsets 0,3,5,8,10,13.
- div_wr with div_val=4, then start nbits=2:
  - pattern 1100 1100; div_cur=4; 8 busy cycles.
- Mid-burst div_wr with div_val=6, then 7, while D=5:
  - current burst stays 11100; div_cur becomes 7 at done.
  - next burst pattern is 1111000.
- div_val=1 is clamped to 2, giving pattern 10 per period.
- start with nbits=0 gives done next cycle with sclk_out held at 0.
- abort at bit_idx=1 (D=5, nbits=4):
  - next cycle: sclk_out=0, done=1, aborted=1.
  - a following start clears aborted.
- rst asserted mid-burst:
  - next cycle all outputs 0 with no done pulse, and div_cur=5.
  - start still ignored during busy is checked.

Source files
------------

// File: rtl/cfg_sclk_sequencer_if.sv
// rtl/cfg_sclk_sequencer_if.sv - host/status bundle for the serial config clock sequencer
interface cfg_sclk_sequencer_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic             div_wr;
    logic [DIV_W-1:0] div_val;
    logic             start;
    logic [CNT_W-1:0] nbits;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             sclk_out;
    logic             sclk_rise;
    logic             sclk_fall;
    logic [CNT_W-1:0] bit_idx;
    logic [DIV_W-1:0] div_cur;

    modport master (
        output div_wr, div_val, start, nbits, abort,
        input  busy, done, aborted, sclk_out, sclk_rise, sclk_fall, bit_idx, div_cur
    );

    modport slave (
        input  div_wr, div_val, start, nbits, abort,
        output busy, done, aborted, sclk_out, sclk_rise, sclk_fall, bit_idx, div_cur
    );
endinterface

// File: rtl/cfg_sclk_sequencer.sv
// rtl/cfg_sclk_sequencer.sv - burst generator for the divided pixel-config shift clock
module cfg_sclk_sequencer #(
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input logic               clkin_i,
    input logic               rst_i,
    cfg_sclk_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             sclk_q, sclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic [DIV_W-1:0] hi_len;
    logic             pend_any;
    logic [DIV_W-1:0] pend_any_val;
    logic             finish;

    always_ff @(posedge clkin_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_RESET;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            nbits_q    <= '0;
            bit_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            sclk_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            nbits_q    <= nbits_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            sclk_q     <= sclk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    // Outputs are computed for the cycle being entered, so every port is a plain flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        pend_d       = pend_q;
        pend_val_d   = pend_val_q;
        nbits_d      = nbits_q;
        bit_d        = bit_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        sclk_d       = 1'b0;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        finish       = 1'b0;
        hi_len       = div_q - (div_q >> 1);
        pend_any     = pend_q | bus.div_wr;
        pend_any_val = bus.div_wr ? clamp_div(bus.div_val) : pend_val_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                bit_d  = '0;
                if (bus.div_wr) begin
                    div_d = clamp_div(bus.div_val);
                end
                if (bus.start) begin
                    aborted_d = 1'b0;
                    if (bus.nbits != '0) begin
                        state_d = RUN;
                        nbits_d = bus.nbits;
                        busy_d  = 1'b1;
                        sclk_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                pend_d     = pend_any;
                pend_val_d = pend_any_val;
                if (bus.abort) begin
                    finish    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_q == div_q - 1'b1) begin
                    if (bit_q == nbits_q - 1'b1) begin
                        finish = 1'b1;
                    end else begin
                        cnt_d  = '0;
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                        rise_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    sclk_d = (cnt_d < hi_len);
                    fall_d = (cnt_d == hi_len);
                end
            end
            default: state_d = IDLE;
        endcase

        // A divisor written mid-burst takes effect exactly as the burst retires.
        if (finish) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sclk_d  = 1'b0;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            pend_d  = 1'b0;
            if (pend_any) begin
                div_d = pend_any_val;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.sclk_out  = sclk_q;
    assign bus.sclk_rise = rise_q;
    assign bus.sclk_fall = fall_q;
    assign bus.bit_idx   = bit_q;
    assign bus.div_cur   = div_q;
endmodule

// File: tb/tb_cfg_sclk_sequencer.sv
// tb/tb_cfg_sclk_sequencer.sv - randomized bench with a period/phase arithmetic reference model
module tb_cfg_sclk_sequencer;
    localparam int DIV_W = 8;
    localparam int CNT_W = 16;

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    always #5 clkin = ~clkin;

    cfg_sclk_sequencer_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus();

    cfg_sclk_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(5)) dut (
        .clkin_i (clkin),
        .rst_i   (rst),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a burst is "k cycles since acceptance"; period = k / D, phase = k % D.
    bit m_active, m_pend, m_abt, m_done;
    int m_k, m_n, m_div, m_pval;

    function automatic int clamp(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(posedge clkin) begin
        if (rst) begin
            m_active = 0; m_pend = 0; m_abt = 0; m_done = 0;
            m_k = 0; m_n = 0; m_div = 5; m_pval = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (bus.div_wr) m_div = clamp(int'(bus.div_val));
                if (bus.start) begin
                    m_abt = 0;
                    if (bus.nbits == 0) m_done = 1;
                    else begin
                        m_active = 1; m_k = 0; m_n = int'(bus.nbits);
                    end
                end
            end else begin
                if (bus.div_wr) begin
                    m_pend = 1; m_pval = clamp(int'(bus.div_val));
                end
                if (bus.abort || (m_k + 1 == m_n * m_div)) begin
                    m_active = 0; m_done = 1;
                    if (bus.abort) m_abt = 1;
                    if (m_pend) begin
                        m_div = m_pval; m_pend = 0;
                    end
                end else begin
                    m_k++;
                end
            end
        end
    end

    always @(negedge clkin) begin
        if (chk_en) begin
            int ph, hl;
            logic [29:0] e, a;
            ph = m_k % m_div;
            hl = m_div - m_div / 2;
            e = {m_active, m_done, m_abt,
                 m_active && (ph < hl), m_active && (ph == 0), m_active && (ph == hl),
                 m_active ? 16'(m_k / m_div) : 16'd0, 8'(m_div)};
            a = {bus.busy, bus.done, bus.aborted, bus.sclk_out, bus.sclk_rise, bus.sclk_fall,
                 bus.bit_idx, bus.div_cur};
            check("model_outputs", 64'(a), 64'(e));
        end
    end

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic idle_inputs();
        bus.div_wr = 0; bus.div_val = '0; bus.start = 0; bus.nbits = '0; bus.abort = 0;
    endtask

    task automatic write_div(input int v);
        bus.div_wr = 1; bus.div_val = DIV_W'(v);
        step();
        bus.div_wr = 0;
    endtask

    // Runs one burst; optional mid-burst div writes / start at given cycle numbers (-1 = none).
    task automatic run_burst(input int nb, input int wc1, input int wv1, input int wc2,
                             input int wv2, input int sc,
                             output logic [63:0] pat, output int nbusy, output int done_at,
                             output logic [63:0] rmask, output logic [63:0] fmask,
                             output int div_done);
        pat = '0; nbusy = 0; done_at = -1; rmask = '0; fmask = '0; div_done = -1;
        bus.start = 1; bus.nbits = CNT_W'(nb);
        step();
        bus.start = 0;
        for (int c = 1; c < 2000; c++) begin
            if (bus.busy) begin
                pat = {pat[62:0], bus.sclk_out};
                nbusy++;
                if (c <= 64) begin
                    rmask[c-1] = bus.sclk_rise;
                    fmask[c-1] = bus.sclk_fall;
                end
            end
            if (bus.done) begin
                done_at = c; div_done = int'(bus.div_cur);
                break;
            end
            bus.div_wr  = (c == wc1) || (c == wc2);
            bus.div_val = DIV_W'((c == wc1) ? wv1 : wv2);
            bus.start   = (c == sc);
            bus.nbits   = CNT_W'(nb);
            step();
            bus.div_wr = 0; bus.start = 0;
        end
        if (done_at < 0) check("burst_timeout", 64'd1, 64'd0);
    endtask

    logic [63:0] pat, rm, fm;
    int nb_busy, d_at, d_div;

    initial begin
        idle_inputs();
        rst = 1;
        step();
        chk_en = 1;
        step();
        step();
        rst = 0;
        check("reset_outputs", 64'({bus.busy, bus.done, bus.aborted, bus.sclk_out,
              bus.sclk_rise, bus.sclk_fall, bus.bit_idx}), 64'd0);
        check("reset_div", 64'(bus.div_cur), 64'd5);

        run_burst(3, -1, 0, -1, 0, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t1_pattern", pat, 64'b111001110011100);
        check("t1_busy", 64'(nb_busy), 64'd15);
        check("t1_done_at", 64'(d_at), 64'd16);
        check("t1_rise", rm, 64'h421);
        check("t1_fall", fm, 64'h2108);

        write_div(4);
        check("t2_div", 64'(bus.div_cur), 64'd4);
        run_burst(2, -1, 0, -1, 0, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t2_pattern", pat, 64'b11001100);
        check("t2_busy", 64'(nb_busy), 64'd8);

        write_div(5);
        run_burst(1, 2, 6, 3, 7, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t3_pattern", pat, 64'b11100);
        check("t3_div_at_done", 64'(d_div), 64'd7);
        run_burst(1, -1, 0, -1, 0, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t3_next_pattern", pat, 64'b1111000);

        write_div(1);
        check("t4_clamp", 64'(bus.div_cur), 64'd2);
        run_burst(2, -1, 0, -1, 0, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t4_pattern", pat, 64'b1010);

        run_burst(0, -1, 0, -1, 0, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t5_done_at", 64'(d_at), 64'd1);
        check("t5_busy", 64'(nb_busy), 64'd0);
        check("t5_sclk", 64'(bus.sclk_out), 64'd0);

        write_div(5);
        bus.start = 1; bus.nbits = CNT_W'(4);
        step();
        bus.start = 0;
        for (int c = 0; c < 200 && bus.bit_idx != 1; c++) step();
        check("t6_reach_bit1", 64'(bus.bit_idx), 64'd1);
        bus.abort = 1;
        step();
        bus.abort = 0;
        check("t6_abort_state", 64'({bus.sclk_out, bus.sclk_fall, bus.busy, bus.done, bus.aborted}),
              64'b00011);
        run_burst(1, -1, 0, -1, 0, -1, pat, nb_busy, d_at, rm, fm, d_div);
        check("t6_aborted_cleared", 64'(bus.aborted), 64'd0);

        run_burst(3, -1, 0, -1, 0, 4, pat, nb_busy, d_at, rm, fm, d_div);
        check("t7_start_ignored_busy", 64'(nb_busy), 64'd15);
        step();
        check("t7_no_queued", 64'(bus.busy), 64'd0);

        write_div(9);
        bus.start = 1; bus.nbits = CNT_W'(4);
        step();
        bus.start = 0;
        repeat (7) step();
        rst = 1;
        step();
        rst = 0;
        check("t8_reset_outputs", 64'({bus.busy, bus.done, bus.aborted, bus.sclk_out,
              bus.sclk_rise, bus.sclk_fall, bus.bit_idx}), 64'd0);
        check("t8_reset_div", 64'(bus.div_cur), 64'd5);
        step();
        check("t8_no_done", 64'(bus.done), 64'd0);

        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            bus.start   = ($urandom_range(0, 7) == 0);
            bus.nbits   = CNT_W'($urandom_range(0, 4));
            bus.abort   = ($urandom_range(0, 39) == 0);
            bus.div_wr  = ($urandom_range(0, 9) == 0);
            bus.div_val = DIV_W'($urandom_range(0, 9));
            step();
        end
        idle_inputs();
        rst = 0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
